shot_round_control: RTL



---
 rtl/shot_round_control.sv | 116 +++++++++++
 1 files changed

// File: rtl/shot_round_control.sv
// shot_round_control: per-round KEEPER shot engine (random zone, countdown, save judge, result pulse).
// Optional SHOT_SPEEDUP_EN shortens each countdown by 50 ms per completed round, floored at a quarter.
package game_pkg;
    typedef enum logic [1:0] {MENU, KEEPER, SHOOTER, RESULT} g_state;
endpackage

module shot_round_control #(
    parameter int MS_TICKS     = 65000,
    parameter int SHOT_TIME_MS = 1000,
    parameter int GAP_TIME_MS  = 500,
    parameter int GOAL_X0      = 256,
    parameter int GOAL_Y0      = 160,
    parameter int ZONE_W       = 170,
    parameter int ZONE_H       = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  game_pkg::g_state game_state,
    input  logic [11:0]      mouse_xpos,
    input  logic [11:0]      mouse_ypos,
    output logic             round_done,
    output logic             is_scored,
    output logic [2:0]       shot_zone,
    output logic             shot_active,
    output logic [9:0]       time_left_ms
);
    localparam int TW = MS_TICKS > 1 ? $clog2(MS_TICKS) : 1;
    typedef enum logic [2:0] {IDLE, AIM, WAIT, JUDGE, GAP} state_t;
    state_t state;
    logic [15:0] lfsr;
    logic [TW-1:0] tick;
    logic [9:0] gap_ms;
    logic [9:0] shot_load;
    logic [1:0] col;
    logic row;
    logic saved;
    logic tick_wrap;
    int x_rel;
    int y_rel;
    assign tick_wrap = tick == TW'(MS_TICKS - 1);
`ifdef SHOT_SPEEDUP_EN
    logic [3:0] round_cnt;
    int speed_ms;
    always_comb begin
        speed_ms  = SHOT_TIME_MS - 50 * int'(round_cnt);
        shot_load = 10'(speed_ms < SHOT_TIME_MS / 4 ? SHOT_TIME_MS / 4 : speed_ms);
    end
    // Counts only judged rounds, so an abort in JUDGE does not advance it.
    always_ff @(posedge clk)
        if (rst || state == IDLE)
            round_cnt <= '0;
        else if (state == JUDGE && game_state == game_pkg::KEEPER && round_cnt != 4'd15)
            round_cnt <= round_cnt + 4'd1;
`else
    assign shot_load = 10'(SHOT_TIME_MS);
`endif
    // Relative coordinates go negative left/above the goal and fail the lower-bound test.
    always_comb begin
        col   = shot_zone >= 3'd3 ? 2'(shot_zone - 3'd3) : shot_zone[1:0];
        row   = shot_zone >= 3'd3;
        x_rel = int'(mouse_xpos) - GOAL_X0;
        y_rel = int'(mouse_ypos) - GOAL_Y0;
        saved = x_rel >= int'(col) * ZONE_W && x_rel < (int'(col) + 1) * ZONE_W &&
                y_rel >= int'(row) * ZONE_H && y_rel < (int'(row) + 1) * ZONE_H;
    end
    always_ff @(posedge clk) begin
        lfsr <= rst ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (rst || game_state != game_pkg::KEEPER) begin
            state        <= IDLE;
            round_done   <= 1'b0;
            is_scored    <= 1'b0;
            shot_zone    <= 3'd0;
            shot_active  <= 1'b0;
            time_left_ms <= 10'd0;
            tick         <= '0;
            gap_ms       <= 10'd0;
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE: state <= AIM;
                AIM: begin
                    shot_zone    <= lfsr[2:0] < 3'd6 ? lfsr[2:0] : lfsr[2:0] - 3'd6;
                    time_left_ms <= shot_load;
                    tick         <= '0;
                    shot_active  <= 1'b1;
                    state        <= WAIT;
                end
                WAIT: begin
                    tick <= tick_wrap ? '0 : tick + 1'b1;
                    if (tick_wrap) begin
                        time_left_ms <= time_left_ms - 10'd1;
                        if (time_left_ms == 10'd1) begin
                            shot_active <= 1'b0;
                            state       <= JUDGE;
                        end
                    end
                end
                JUDGE: begin
                    round_done <= 1'b1;
                    is_scored  <= !saved;
                    gap_ms     <= 10'(GAP_TIME_MS);
                    tick       <= '0;
                    state      <= GAP;
                end
                GAP: begin
                    tick <= tick_wrap ? '0 : tick + 1'b1;
                    if (tick_wrap) begin
                        gap_ms <= gap_ms - 10'd1;
                        if (gap_ms == 10'd1) state <= AIM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
